iir_allpole_eq: RTL and testbench
=================================

Name: iir_allpole_eq

Overview:
- 3-tap all-pole (feedback) IIR equaliser; the inverse-direction companion to the team's 4-tap feedforward FIR.
- Computes y[n] = sat16( x[n] - ((a1*y[n-1] + a2*y[n-2] + a3*y[n-3]) >>> COEFF_FRAC) ).
- Sits after a channel or FIR stage to undo its response.
- Uses one time-shared multiplier sequenced by an FSM, with a valid/ready input handshake and a one-cycle output valid pulse.

Parameters:
- DATA_W, 16, signed sample width for input, output and history.
- COEFF_W, 16, signed coefficient width.
- COEFF_FRAC, 15, fractional bits of coefficients (Q1.15; -32768 = -1.0).
- ACC_W, DATA_W+COEFF_W+3, accumulator width; guarantees no internal overflow.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rstb  in  1  asynchronous active-low reset.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept a sample this cycle.
- i_data  in  DATA_W  signed input sample x[n].
- i_coeff1  in  COEFF_W  signed feedback coefficient a1.
- i_coeff2  in  COEFF_W  signed feedback coefficient a2.
- i_coeff3  in  COEFF_W  signed feedback coefficient a3.
- o_valid  out  1  one-cycle pulse, o_data holds a new y[n].
- o_data  out  DATA_W  signed saturated output y[n]; holds its value between pulses.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; o_valid=0; o_data=0; o_ready=1.
  - History y[n-1..n-3]=0; accumulator and coefficient latches = 0.
- FSM states: IDLE -> MAC1 -> MAC2 -> MAC3 -> FIN -> IDLE.
- IDLE:
  - o_ready=1; o_ready is low in every other state.
  - Handshake when i_valid & o_ready at edge E0.
  - At E0: acc <= sign-extended i_data << COEFF_FRAC; latch i_coeff1..3; go to MAC1.
  - Otherwise stay in IDLE.
- MAC1/MAC2/MAC3 (edges E1/E2/E3): acc <= acc - (a_k * y[n-k]), k=1/2/3, full-precision signed product.
- Single multiplier only; operands selected by state.
- FIN (edge E4):
  - s = acc >>> COEFF_FRAC (arithmetic shift, floor).
  - o_data <= s clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - o_valid <= 1; history shifts: y[n-3]<=y[n-2], y[n-2]<=y[n-1], y[n-1]<=saturated output.
  - Go to IDLE.
- o_valid is high exactly in the cycle after E4, cleared at the next edge.
- Latency: o_valid asserted 4 edges after acceptance.
- Throughput: 1 sample per 5 cycles; the next acceptance edge is E5 at earliest.
- Coefficients and i_data are sampled only at E0; changes during MAC/FIN have no effect on the sample in flight.
- i_valid while o_ready=0: no acceptance, no state change; the upstream holds the sample.
- Feedback uses the saturated output value, never the unsaturated s.
- Reset mid-operation: the in-flight sample is discarded with no o_valid, history is cleared, and the FSM returns to IDLE.
- No internal overflow possible with ACC_W; saturation occurs only at FIN.

Test Plan:
- Reset: hold i_rstb=0 with random inputs -> o_valid=0, o_data=0, o_ready=1; after release, first sample 123 with all coeffs 0 -> o_data=123.
- Passthrough: a1=a2=a3=0, accept 1000 at E0 -> o_ready low E0..E4, o_data=1000 with a single o_valid pulse after E4.
- Decaying impulse: a1=-16384, a2=a3=0, inputs 16384,0,0,0 -> outputs 16384, 8192, 4096, 2048.
- Multi-tap plus floor: a1=0, a2=0, a3=16384, inputs 100,0,0,0,0 -> outputs 100,0,0,-50,0.
- Saturation, both signs:
  - a1=-32768, inputs 30000,30000 -> outputs 30000, 32767 (60000 clamped); third input 0 -> 32767.
  - Inputs -30000,-30000 -> outputs -30000, -32768.
- Handshake and reset abort:
  - i_valid held high continuously -> acceptances exactly every 5 cycles, no sample dropped.
  - Coeff change during MAC2 -> in-flight result unchanged.
  - i_rstb pulsed low during MAC2 -> no o_valid for that sample; next sample 500 with a1=-16384 -> output 500 (history cleared).

Source files
------------

// File: rtl/iir_allpole_eq.sv
// 3-tap all-pole IIR equaliser: y[n] = sat(x[n] - (sum a_k*y[n-k]) >>> COEFF_FRAC).
// One shared multiplier, sequenced IDLE -> MAC1 -> MAC2 -> MAC3 -> FIN.
module iir_allpole_eq #(
  parameter int DATA_W     = 16,
  parameter int COEFF_W    = 16,
  parameter int COEFF_FRAC = 15,
  parameter int ACC_W      = DATA_W + COEFF_W + 3
) (
  input  logic               i_clk,
  input  logic               i_rstb,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [COEFF_W-1:0] i_coeff1,
  input  logic [COEFF_W-1:0] i_coeff2,
  input  logic [COEFF_W-1:0] i_coeff3,
  output logic               o_valid,
  output logic [DATA_W-1:0]  o_data
);

  localparam int PROD_W = DATA_W + COEFF_W;
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [2:0] {IDLE, MAC1, MAC2, MAC3, FIN} state_t;

  state_t                    state, state_nx;
  logic signed [ACC_W-1:0]   acc, acc_shr, prod_ext;
  logic signed [COEFF_W-1:0] c1, c2, c3, mul_c;
  logic signed [DATA_W-1:0]  y1, y2, y3, mul_y, y_sat;
  logic signed [PROD_W-1:0]  prod;
  logic                      accept;

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = MAC1;
      MAC1:    state_nx = MAC2;
      MAC2:    state_nx = MAC3;
      MAC3:    state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
  end

  assign accept = i_valid & o_ready;

  // Operand mux feeding the single multiplier; tap k is used in state MACk.
  always_comb begin
    mul_c = '0;
    mul_y = '0;
    case (state)
      MAC1:    begin mul_c = c1; mul_y = y1; end
      MAC2:    begin mul_c = c2; mul_y = y2; end
      MAC3:    begin mul_c = c3; mul_y = y3; end
      default: begin mul_c = '0; mul_y = '0; end
    endcase
  end

  always_comb begin
    prod     = mul_c * mul_y;
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    acc_shr  = acc >>> COEFF_FRAC;
    if (acc_shr > Y_MAX)      y_sat = {1'b0, {(DATA_W - 1){1'b1}}};
    else if (acc_shr < Y_MIN) y_sat = {1'b1, {(DATA_W - 1){1'b0}}};
    else                      y_sat = acc_shr[DATA_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      acc     <= '0;
      c1      <= '0;
      c2      <= '0;
      c3      <= '0;
      y1      <= '0;
      y2      <= '0;
      y3      <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= {{(ACC_W - DATA_W){i_data[DATA_W-1]}}, i_data} << COEFF_FRAC;
            c1  <= i_coeff1;
            c2  <= i_coeff2;
            c3  <= i_coeff3;
          end
        end
        MAC1, MAC2, MAC3: acc <= acc - prod_ext;
        FIN: begin
          // History is fed from the clamped value so the loop never sees overflow.
          o_data  <= y_sat;
          o_valid <= 1'b1;
          y3      <= y2;
          y2      <= y1;
          y1      <= y_sat;
        end
        default: acc <= acc;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_allpole_eq.sv
// Scoreboard bench for iir_allpole_eq: driver pushes model results, monitor pops on o_valid.
module tb_iir_allpole_eq;

  logic        i_clk = 1'b0;
  logic        i_rstb = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_data = '0;
  logic [15:0] i_coeff1 = '0;
  logic [15:0] i_coeff2 = '0;
  logic [15:0] i_coeff3 = '0;
  logic        o_valid;
  logic [15:0] o_data;

  iir_allpole_eq #(
    .DATA_W(16),
    .COEFF_W(16),
    .COEFF_FRAC(15)
  ) dut (
    .i_clk(i_clk),
    .i_rstb(i_rstb),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data(i_data),
    .i_coeff1(i_coeff1),
    .i_coeff2(i_coeff2),
    .i_coeff3(i_coeff3),
    .o_valid(o_valid),
    .o_data(o_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          y;
    int unsigned t;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  exp_t        sb[$];
  exp_t        e;
  int          m_y1 = 0, m_y2 = 0, m_y3 = 0;
  int          last_out = 0;
  int unsigned last_acc = 0;
  bit          have_last = 0;
  bit          after_accept = 0;
  bit          busy_valid = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rnd16();
    logic [15:0] v;
    v = 16'($urandom);
    return int'($signed(v));
  endfunction

  // Reference: exact rational arithmetic with floor division and clamping.
  function automatic int ref_step(input int x, input int a1, input int a2, input int a3);
    longint num, q;
    int     y;
    num = longint'(x) * 32768 - (longint'(a1) * m_y1 + longint'(a2) * m_y2 + longint'(a3) * m_y3);
    q = num / 32768;
    if ((num % 32768) != 0 && num < 0) q = q - 1;
    if (q > 32767) y = 32767;
    else if (q < -32768) y = -32768;
    else y = int'(q);
    m_y3 = m_y2;
    m_y2 = m_y1;
    m_y1 = y;
    return y;
  endfunction

  always @(negedge i_clk) begin
    if (!i_rstb) begin
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_data", $signed(o_data), 0);
      chk("rst_o_ready", o_ready, 1);
      last_out = 0;
    end else if (o_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got o_valid=1 expected no pending sample (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("o_data", $signed(o_data), e.y);
        chk("latency", longint'(cyc - e.t), 5);
        last_out = e.y;
      end
    end else begin
      chk("o_data_hold", $signed(o_data), last_out);
    end
  end

  // Wait (scrambling inputs) until o_ready; n = number of busy negedges seen.
  task automatic wait_ready(output int n);
    n = 0;
    while (!o_ready) begin
      if (n >= 20) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got o_ready=0 for %0d cycles expected 1 within 20", n);
        return;
      end
      i_valid  = busy_valid ? 1'b1 : 1'($urandom);
      i_data   = 16'($urandom);
      i_coeff1 = 16'($urandom);
      i_coeff2 = 16'($urandom);
      i_coeff3 = 16'($urandom);
      @(negedge i_clk);
      n++;
    end
    if (after_accept) chk("busy_cycles", n, 4);
    after_accept = 0;
  endtask

  task automatic send(input int x, input int a1, input int a2, input int a3);
    int n;
    wait_ready(n);
    i_valid  = 1'b1;
    i_data   = 16'(x);
    i_coeff1 = 16'(a1);
    i_coeff2 = 16'(a2);
    i_coeff3 = 16'(a3);
    if (have_last) chk("accept_gap", longint'(cyc - last_acc), 5);
    last_acc  = cyc;
    have_last = 1;
    sb.push_back('{ref_step(x, a1, a2, a3), cyc});
    after_accept = 1;
    @(negedge i_clk);
  endtask

  task automatic idle(input int cycles);
    int n;
    wait_ready(n);
    i_valid   = 1'b0;
    have_last = 0;
    repeat (cycles) @(negedge i_clk);
  endtask

  task automatic do_reset(input int cycles);
    #2 i_rstb = 1'b0;
    sb.delete();
    m_y1 = 0; m_y2 = 0; m_y3 = 0;
    have_last = 0;
    after_accept = 0;
    repeat (cycles) begin
      @(negedge i_clk);
      i_valid  = 1'($urandom);
      i_data   = 16'($urandom);
      i_coeff1 = 16'($urandom);
      i_coeff2 = 16'($urandom);
      i_coeff3 = 16'($urandom);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    #2 i_rstb = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    @(negedge i_clk);
    do_reset(5);

    send(123, 0, 0, 0);
    idle(2);
    send(1000, 0, 0, 0);
    idle(3);

    do_reset(1);
    send(16384, -16384, 0, 0);
    for (int i = 0; i < 3; i++) send(0, -16384, 0, 0);
    idle(2);

    do_reset(1);
    send(100, 0, 0, 16384);
    for (int i = 0; i < 4; i++) send(0, 0, 0, 16384);
    idle(2);

    do_reset(1);
    send(30000, -32768, 0, 0);
    send(30000, -32768, 0, 0);
    send(0, -32768, 0, 0);
    idle(2);

    do_reset(1);
    send(-30000, -32768, 0, 0);
    send(-30000, -32768, 0, 0);
    idle(2);

    busy_valid = 1;
    for (int i = 0; i < 20; i++) send(rnd16(), rnd16() / 4, rnd16() / 4, rnd16() / 4);
    busy_valid = 0;
    idle(2);

    for (int i = 0; i < 200; i++) begin
      send(rnd16(), rnd16(), rnd16(), rnd16());
      if ($urandom_range(0, 7) == 0) idle($urandom_range(0, 3));
    end
    idle(2);

    do_reset(1);
    send(777, rnd16(), rnd16(), rnd16());
    @(negedge i_clk);
    do_reset(2);
    send(500, -16384, 0, 0);
    idle(10);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
